// File: rtl/regfile_alu_seq.sv
// Sequencer + ALU stage for a dual-read register file: one micro-op per 4 cycles.
// Optional REGFILE_ALU_MUL_EN turns op 7 into an 8-cycle shift-add MUL (otherwise op 7 is a NOP).
module regfile_alu_seq #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned AW    = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             instr_valid,
  output logic             instr_ready,
  input  logic [2:0]       op,
  input  logic [AW-1:0]    rd,
  input  logic [AW-1:0]    ra,
  input  logic [AW-1:0]    rb,
  input  logic [WIDTH-1:0] imm,
  output logic [AW-1:0]    RAA,
  output logic [AW-1:0]    RBA,
  output logic             RAE,
  output logic             RBE,
  input  logic [WIDTH-1:0] portA,
  input  logic [WIDTH-1:0] portB,
  output logic [WIDTH-1:0] D,
  output logic [AW-1:0]    WA,
  output logic             WE,
  output logic [WIDTH-1:0] result,
  output logic             flag_z,
  output logic             flag_c,
  output logic             done
);

  localparam logic [2:0] StIdle  = 3'd0;
  localparam logic [2:0] StRead  = 3'd1;
  localparam logic [2:0] StExec  = 3'd2;
  localparam logic [2:0] StWrite = 3'd3;
  localparam logic [2:0] StMul   = 3'd4;

  localparam logic [2:0] OpAdd = 3'd0;
  localparam logic [2:0] OpSub = 3'd1;
  localparam logic [2:0] OpAnd = 3'd2;
  localparam logic [2:0] OpOr  = 3'd3;
  localparam logic [2:0] OpXor = 3'd4;
  localparam logic [2:0] OpMov = 3'd5;
  localparam logic [2:0] OpLdi = 3'd6;
  localparam logic [2:0] OpMul = 3'd7;

  logic [2:0]       state_q;
  logic [2:0]       op_q;
  logic [AW-1:0]    rd_q;
  logic [WIDTH-1:0] imm_q;
  logic [WIDTH-1:0] opa_q;
  logic [WIDTH-1:0] opb_q;
  logic             carry_q;

  logic [WIDTH-1:0] alu_res;
  logic             alu_c;

  always_comb begin
    alu_res = '0;
    alu_c   = 1'b0;
    case (op_q)
      OpAdd:   {alu_c, alu_res} = {1'b0, opa_q} + {1'b0, opb_q};
      // Bit WIDTH of the extended difference is the borrow (A < B).
      OpSub:   {alu_c, alu_res} = {1'b0, opa_q} - {1'b0, opb_q};
      OpAnd:   alu_res = opa_q & opb_q;
      OpOr:    alu_res = opa_q | opb_q;
      OpXor:   alu_res = opa_q ^ opb_q;
      OpMov:   alu_res = opa_q;
      OpLdi:   alu_res = imm_q;
      default: alu_res = '0;
    endcase
  end

`ifdef REGFILE_ALU_MUL_EN
  localparam int unsigned CntW = $clog2(WIDTH);

  logic [CntW-1:0]    mul_cnt_q;
  logic [2*WIDTH-1:0] mul_acc_q;
  logic [2*WIDTH-1:0] mul_acc_next;

  // One multiplier bit per cycle, LSB first.
  always_comb begin
    mul_acc_next = mul_acc_q;
    if (opb_q[mul_cnt_q]) begin
      mul_acc_next = mul_acc_q + ({{WIDTH{1'b0}}, opa_q} << mul_cnt_q);
    end
  end
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      op_q        <= '0;
      rd_q        <= '0;
      imm_q       <= '0;
      opa_q       <= '0;
      opb_q       <= '0;
      carry_q     <= 1'b0;
      instr_ready <= 1'b1;
      RAA         <= '0;
      RBA         <= '0;
      RAE         <= 1'b0;
      RBE         <= 1'b0;
      D           <= '0;
      WA          <= '0;
      WE          <= 1'b0;
      result      <= '0;
      flag_z      <= 1'b0;
      flag_c      <= 1'b0;
      done        <= 1'b0;
`ifdef REGFILE_ALU_MUL_EN
      mul_cnt_q   <= '0;
      mul_acc_q   <= '0;
`endif
    end else begin
      WE   <= 1'b0;
      done <= 1'b0;
      case (state_q)
        StIdle: begin
          if (instr_valid) begin
            op_q        <= op;
            rd_q        <= rd;
            imm_q       <= imm;
            RAA         <= ra;
            RBA         <= rb;
            RAE         <= (op != OpLdi);
            RBE         <= (op != OpLdi);
            instr_ready <= 1'b0;
            state_q     <= StRead;
          end
        end
        StRead: begin
          opa_q   <= portA;
          opb_q   <= portB;
          RAE     <= 1'b0;
          RBE     <= 1'b0;
          state_q <= StExec;
`ifdef REGFILE_ALU_MUL_EN
          if (op_q == OpMul) begin
            mul_cnt_q <= '0;
            mul_acc_q <= '0;
            state_q   <= StMul;
          end
`endif
        end
        StExec: begin
          D       <= alu_res;
          WA      <= rd_q;
          carry_q <= alu_c;
          // Op 7 only reaches EXEC as a NOP: keep the done pulse, suppress the write.
          WE      <= (op_q != OpMul);
          done    <= 1'b1;
          state_q <= StWrite;
        end
        StWrite: begin
          if (WE) begin
            result <= D;
            flag_z <= (D == '0);
            flag_c <= carry_q;
          end
          instr_ready <= 1'b1;
          state_q     <= StIdle;
        end
`ifdef REGFILE_ALU_MUL_EN
        StMul: begin
          mul_acc_q <= mul_acc_next;
          mul_cnt_q <= mul_cnt_q + 1'b1;
          if (mul_cnt_q == CntW'(WIDTH - 1)) begin
            D       <= mul_acc_next[WIDTH-1:0];
            WA      <= rd_q;
            carry_q <= |mul_acc_next[2*WIDTH-1:WIDTH];
            WE      <= 1'b1;
            done    <= 1'b1;
            state_q <= StWrite;
          end
        end
`endif
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule
